// File: rtl/ui_pkg.sv
// Shared constants for the user-input front end: key/switch counts, key roles, default timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ui_pkg;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 18;

  // Key roles as seen by the mode controller
  localparam int KEY_REC  = 0;
  localparam int KEY_PLAY = 1;
  localparam int KEY_STOP = 2;
  localparam int KEY_AUX  = 3;

  // 20 ms debounce and 1 s long-press at the 12 MHz system clock
  localparam int DEBOUNCE_DEFAULT = 240000;
  localparam int LONG_DEFAULT     = 12000000;

  // Counter width able to hold values 0..n-1, never narrower than one bit
  function automatic int ctr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One key: 2-flop synchronizer, debounce counter, level register, press/release pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from a raw edge to the level change and its pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when presented.
module debounce_bit
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = ctr_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          differ;

  // Synchronizer flops idle high so a released key never looks pressed out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= key_n_i;
      sync_q <= meta_q;
    end
  end

  // Pin is active-low, level is active-high
  assign differ = (~sync_q) ^ level_q;

  // Count stable disagreement; accept the new level once it has held long enough
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (differ) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q;
        rel_d   = level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state and registered pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronize/debounce KEY and SW pins into clean levels and single-cycle events.
// Latency: DEBOUNCE_CYCLES+2 edges raw-to-output; long press LONG_CYCLES edges after level rise.
// Backpressure: none; events are one-cycle pulses. Optional long-press via INPUT_LONGPRESS_EN.
module input_conditioner
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_key_n,
  input  logic [NUM_SW-1:0]   i_sw,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_key_press,
  output logic [NUM_KEYS-1:0] o_key_release,
  output logic [NUM_KEYS-1:0] o_key_long,
  output logic [NUM_SW-1:0]   o_sw,
  output logic                o_sw_change
);

  // ---------------------------------------------------------------- keys
  logic [NUM_KEYS-1:0] key_level;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .key_n_i   (i_key_n[k]),
      .level_o   (key_level[k]),
      .press_o   (o_key_press[k]),
      .release_o (o_key_release[k])
    );
  end

  assign o_key_level = key_level;

  // ------------------------------------------------------------ switches
  localparam int SCW = ctr_w(DEBOUNCE_CYCLES);
  localparam logic [SCW-1:0] SW_CNT_LAST = SCW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sw_meta_q;
  logic [NUM_SW-1:0] sw_snap_q;
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic [SCW-1:0]    sw_cnt_q, sw_cnt_d;
  logic              sw_chg_q, sw_chg_d;
  logic              sw_moving;

  // The second synchronizer flop doubles as the snapshot: it reloads every edge,
  // which is the same as reloading only when it differs from the first stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_meta_q <= '0;
      sw_snap_q <= '0;
    end else begin
      sw_meta_q <= i_sw;
      sw_snap_q <= sw_meta_q;
    end
  end

  // A marginal first-stage value can only restart the settle window, never reach o_sw
  assign sw_moving = (sw_meta_q != sw_snap_q);

  // Shared settle counter: any bit moving restarts it; a settled new vector is published
  always_comb begin
    sw_d     = sw_q;
    sw_cnt_d = '0;
    sw_chg_d = 1'b0;
    if (!sw_moving && (sw_snap_q != sw_q)) begin
      if (sw_cnt_q == SW_CNT_LAST) begin
        sw_d     = sw_snap_q;
        sw_chg_d = 1'b1;
      end else begin
        sw_cnt_d = sw_cnt_q + SCW'(1);
      end
    end
  end

  // Switch debounce state and change pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_q     <= '0;
      sw_cnt_q <= '0;
      sw_chg_q <= 1'b0;
    end else begin
      sw_q     <= sw_d;
      sw_cnt_q <= sw_cnt_d;
      sw_chg_q <= sw_chg_d;
    end
  end

  assign o_sw        = sw_q;
  assign o_sw_change = sw_chg_q;

  // ---------------------------------------------------------- long press
`ifdef INPUT_LONGPRESS_EN
  localparam int LW = ctr_w(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0]       hold_q [NUM_KEYS];
  logic [LW-1:0]       hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_q, long_d;

  // Hold counters run while a key is down, fire once, then park at saturation
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      hold_d[k] = hold_q[k];
      long_d[k] = 1'b0;
      if (!key_level[k]) begin
        hold_d[k] = '0;
      end else if (hold_q[k] == HOLD_LAST) begin
        hold_d[k] = HOLD_SAT;
        long_d[k] = 1'b1;
      end else if (hold_q[k] != HOLD_SAT) begin
        hold_d[k] = hold_q[k] + LW'(1);
      end
    end
  end

  // Hold counter and long-press pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_KEYS; k++) hold_q[k] <= '0;
      long_q <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) hold_q[k] <= hold_d[k];
      long_q <= long_d;
    end
  end

  assign o_key_long = long_q;
`else
  // Long press not built; port kept so the controller interface does not change
  assign o_key_long = '0;
`endif

endmodule
